// File: rtl/bc_pkg.sv
// Shared breadcrumb-buffer definitions: arbiter state encoding and the
// fifo_src tag values that downstream readers decode.
package bc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GNT_AVOID = 2'd1,
        GNT_PWM   = 2'd2
    } arb_state_e;

    localparam logic SRC_AVOID = 1'b0;
    localparam logic SRC_PWM   = 1'b1;

    localparam int DEFAULT_DATA_W = 16;

endpackage

// File: rtl/bc_write_arbiter.sv
// Round-robin, burst-bounded write arbiter feeding the breadcrumb FIFO from
// the Avoidance and PWM producers, with per-source accepted-word counters.
module bc_write_arbiter
    import bc_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              avoid_in_valid,
    input  logic [DATA_W-1:0] avoid_in_data,
    output logic              avoid_in_rdy,
    input  logic              pwm_in_valid,
    input  logic [DATA_W-1:0] pwm_in_data,
    output logic              pwm_in_rdy,
    input  logic              fifo_full,
    input  logic              fifo_wr_rst_busy,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_src,
    output logic [1:0]        grant,
    output logic [CNT_W-1:0]  avoid_word_cnt,
    output logic [CNT_W-1:0]  pwm_word_cnt
);

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    arb_state_e       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0] avoid_cnt_q, avoid_cnt_d;
    logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;

    logic stall;
    logic avoid_xfer;
    logic pwm_xfer;

    assign stall      = fifo_full || fifo_wr_rst_busy;
    assign avoid_xfer = avoid_in_valid && avoid_in_rdy;
    assign pwm_xfer   = pwm_in_valid && pwm_in_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_PWM;
            burst_cnt_q  <= 8'd0;
            avoid_cnt_q  <= '0;
            pwm_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            avoid_cnt_q  <= avoid_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
        end
    end

    // A grant ends on a valid drop or on the last word of a burst; the other
    // source wins if it is waiting, otherwise the current source re-bursts.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (avoid_in_valid && (!pwm_in_valid || last_grant_q == SRC_PWM)) begin
                    state_d      = GNT_AVOID;
                    last_grant_d = SRC_AVOID;
                    burst_cnt_d  = 8'd0;
                end else if (pwm_in_valid) begin
                    state_d      = GNT_PWM;
                    last_grant_d = SRC_PWM;
                    burst_cnt_d  = 8'd0;
                end
            end
            GNT_AVOID: begin
                if (!avoid_in_valid || (avoid_xfer && burst_cnt_q == BURST_LAST)) begin
                    burst_cnt_d = 8'd0;
                    if (pwm_in_valid) begin
                        state_d      = GNT_PWM;
                        last_grant_d = SRC_PWM;
                    end else if (avoid_in_valid) begin
                        state_d      = GNT_AVOID;
                        last_grant_d = SRC_AVOID;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (avoid_xfer) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
            end
            GNT_PWM: begin
                if (!pwm_in_valid || (pwm_xfer && burst_cnt_q == BURST_LAST)) begin
                    burst_cnt_d = 8'd0;
                    if (avoid_in_valid) begin
                        state_d      = GNT_AVOID;
                        last_grant_d = SRC_AVOID;
                    end else if (pwm_in_valid) begin
                        state_d      = GNT_PWM;
                        last_grant_d = SRC_PWM;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (pwm_xfer) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = 8'd0;
            end
        endcase
    end

    always_comb begin
        avoid_cnt_d = avoid_cnt_q;
        pwm_cnt_d   = pwm_cnt_q;
        if (avoid_xfer) begin
            avoid_cnt_d = avoid_cnt_q + CNT_W'(1);
        end
        if (pwm_xfer) begin
            pwm_cnt_d = pwm_cnt_q + CNT_W'(1);
        end
    end

    // Zero-latency data path: the granted producer drives the FIFO directly.
    always_comb begin
        avoid_in_rdy = 1'b0;
        pwm_in_rdy   = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_din     = '0;
        fifo_src     = SRC_AVOID;
        grant        = 2'b00;
        case (state_q)
            GNT_AVOID: begin
                avoid_in_rdy = !stall;
                fifo_wr_en   = avoid_in_valid && !stall;
                fifo_din     = avoid_in_data;
                fifo_src     = SRC_AVOID;
                grant        = 2'b01;
            end
            GNT_PWM: begin
                pwm_in_rdy = !stall;
                fifo_wr_en = pwm_in_valid && !stall;
                fifo_din   = pwm_in_data;
                fifo_src   = SRC_PWM;
                grant      = 2'b10;
            end
            default: begin
            end
        endcase
    end

    assign avoid_word_cnt = avoid_cnt_q;
    assign pwm_word_cnt   = pwm_cnt_q;

endmodule

// File: tb/tb_bc_write_arbiter.sv
// Directed bench for bc_write_arbiter: two instances (bursts of 8 and 4)
// share the producer/FIFO inputs; each phase checks the instance it targets.
module tb_bc_write_arbiter;
    import bc_pkg::*;

    logic        clk;
    logic        rst;
    logic        avoidValid;
    logic [15:0] avoidData;
    logic        pwmValid;
    logic [15:0] pwmData;
    logic        fifoFull;
    logic        fifoBusy;

    logic        a8Rdy, p8Rdy, wr8, src8;
    logic [15:0] din8, acnt8, pcnt8;
    logic [1:0]  gnt8;
    logic        a4Rdy, p4Rdy, wr4, src4;
    logic [15:0] din4, acnt4, pcnt4;
    logic [1:0]  gnt4;

    int errors = 0;
    int checks = 0;

    bc_write_arbiter #(.DATA_W(16), .MAX_BURST(8), .CNT_W(16)) u8 (
        .clk(clk), .rst(rst),
        .avoid_in_valid(avoidValid), .avoid_in_data(avoidData), .avoid_in_rdy(a8Rdy),
        .pwm_in_valid(pwmValid), .pwm_in_data(pwmData), .pwm_in_rdy(p8Rdy),
        .fifo_full(fifoFull), .fifo_wr_rst_busy(fifoBusy),
        .fifo_wr_en(wr8), .fifo_din(din8), .fifo_src(src8), .grant(gnt8),
        .avoid_word_cnt(acnt8), .pwm_word_cnt(pcnt8)
    );

    bc_write_arbiter #(.DATA_W(16), .MAX_BURST(4), .CNT_W(16)) u4 (
        .clk(clk), .rst(rst),
        .avoid_in_valid(avoidValid), .avoid_in_data(avoidData), .avoid_in_rdy(a4Rdy),
        .pwm_in_valid(pwmValid), .pwm_in_data(pwmData), .pwm_in_rdy(p4Rdy),
        .fifo_full(fifoFull), .fifo_wr_rst_busy(fifoBusy),
        .fifo_wr_en(wr4), .fifo_din(din4), .fifo_src(src4), .grant(gnt4),
        .avoid_word_cnt(acnt4), .pwm_word_cnt(pcnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkWrite(input int sel, input string tag, input logic expWr,
                              input logic [15:0] expDin, input logic expSrc, input logic [1:0] expGnt);
        checkOutput({tag, ".wr_en"}, 32'(sel == 8 ? wr8 : wr4), 32'(expWr));
        checkOutput({tag, ".din"},   32'(sel == 8 ? din8 : din4), 32'(expDin));
        checkOutput({tag, ".src"},   32'(sel == 8 ? src8 : src4), 32'(expSrc));
        checkOutput({tag, ".grant"}, 32'(sel == 8 ? gnt8 : gnt4), 32'(expGnt));
    endtask

    task automatic checkReset(input string tag);
        checkWrite(8, {tag, ".u8"}, 1'b0, 16'h0000, SRC_AVOID, 2'b00);
        checkWrite(4, {tag, ".u4"}, 1'b0, 16'h0000, SRC_AVOID, 2'b00);
        checkOutput({tag, ".u8.rdy"}, 32'({a8Rdy, p8Rdy}), 32'(2'b00));
        checkOutput({tag, ".u4.rdy"}, 32'({a4Rdy, p4Rdy}), 32'(2'b00));
        checkOutput({tag, ".u8.cnt"}, {acnt8, pcnt8}, 32'h0);
        checkOutput({tag, ".u4.cnt"}, {acnt4, pcnt4}, 32'h0);
        checkOutput({tag, ".u8.burst"}, 32'(u8.burst_cnt_q), 32'd0);
    endtask

    task automatic applyStimulus(input logic av, input logic [15:0] ad, input logic pv,
                                 input logic [15:0] pd, input logic full, input logic busy);
        avoidValid = av;
        avoidData  = ad;
        pwmValid   = pv;
        pwmData    = pd;
        fifoFull   = full;
        fifoBusy   = busy;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int ai;
        int bi;
        int expSrc [12];
        logic [15:0] expDin;

        // Reset values while rst is held
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkReset("rst");

        // Avoidance alone, 20 words, burst of 8 refreshes with no bubble
        applyStimulus(1'b1, 16'h0001, 1'b0, 16'h0, 1'b0, 1'b0);
        releaseReset();
        @(negedge clk);
        checkWrite(8, "t1.idle", 1'b0, 16'h0000, SRC_AVOID, 2'b00);
        checkOutput("t1.idle.rdy", 32'(a8Rdy), 32'd0);
        nextCycle();
        for (int i = 1; i <= 20; i++) begin
            avoidData = 16'(i);
            @(negedge clk);
            checkWrite(8, $sformatf("t1.w%0d", i), 1'b1, 16'(i), SRC_AVOID, 2'b01);
            checkOutput($sformatf("t1.burst%0d", i), 32'(u8.burst_cnt_q), 32'((i - 1) % 8));
            nextCycle();
        end
        avoidValid = 1'b0;
        @(negedge clk);
        checkOutput("t1.cnt", 32'(acnt8), 32'd20);
        checkOutput("t1.drop.wr", 32'(wr8), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("t1.end.grant", 32'(gnt8), 32'(2'b00));

        // Both valid from reset, burst of 4: A0-A3, B0-B3, A4-A7
        rst = 1'b1;
        expSrc = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        ai = 0;
        bi = 0;
        applyStimulus(1'b1, 16'hA000, 1'b1, 16'hB000, 1'b0, 1'b0);
        releaseReset();
        @(negedge clk);
        checkWrite(4, "t2.idle", 1'b0, 16'h0000, SRC_AVOID, 2'b00);
        nextCycle();
        for (int k = 0; k < 12; k++) begin
            avoidData = 16'hA000 + 16'(ai);
            pwmData   = 16'hB000 + 16'(bi);
            expDin    = (expSrc[k] == 1) ? 16'hB000 + 16'(bi) : 16'hA000 + 16'(ai);
            @(negedge clk);
            checkWrite(4, $sformatf("t2.w%0d", k), 1'b1, expDin, 1'(expSrc[k]),
                       (expSrc[k] == 1) ? 2'b10 : 2'b01);
            if (expSrc[k] == 1) bi++;
            else ai++;
            nextCycle();
        end

        // Avoidance burst stalled by fifo_full for 5 cycles after word 2
        rst = 1'b1;
        applyStimulus(1'b1, 16'h0C01, 1'b0, 16'h0, 1'b0, 1'b0);
        releaseReset();
        nextCycle();
        for (int w = 1; w <= 6; w++) begin
            if (w == 3) begin
                fifoFull = 1'b1;
                avoidData = 16'h0C03;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    checkOutput($sformatf("t3.full%0d.rdy", s), 32'(a8Rdy), 32'd0);
                    checkOutput($sformatf("t3.full%0d.wr", s), 32'(wr8), 32'd0);
                    checkOutput($sformatf("t3.full%0d.burst", s), 32'(u8.burst_cnt_q), 32'd2);
                    checkOutput($sformatf("t3.full%0d.grant", s), 32'(gnt8), 32'(2'b01));
                    nextCycle();
                end
                fifoFull = 1'b0;
            end
            if (w == 5) begin
                fifoBusy = 1'b1;
                avoidData = 16'h0C05;
                for (int s = 0; s < 2; s++) begin
                    @(negedge clk);
                    checkOutput($sformatf("t3.busy%0d.wr", s), 32'(wr8), 32'd0);
                    checkOutput($sformatf("t3.busy%0d.burst", s), 32'(u8.burst_cnt_q), 32'd4);
                    nextCycle();
                end
                fifoBusy = 1'b0;
            end
            avoidData = 16'h0C00 + 16'(w);
            @(negedge clk);
            checkWrite(8, $sformatf("t3.w%0d", w), 1'b1, 16'h0C00 + 16'(w), SRC_AVOID, 2'b01);
            nextCycle();
        end
        avoidValid = 1'b0;
        @(negedge clk);
        checkOutput("t3.cnt", 32'(acnt8), 32'd6);

        // PWM arrives mid-burst, Avoidance yields after word 1
        rst = 1'b1;
        applyStimulus(1'b1, 16'hD001, 1'b0, 16'h0, 1'b0, 1'b0);
        releaseReset();
        nextCycle();
        pwmValid = 1'b1;
        pwmData  = 16'hE001;
        @(negedge clk);
        checkWrite(8, "t4.a1", 1'b1, 16'hD001, SRC_AVOID, 2'b01);
        checkOutput("t4.a1.prdy", 32'(p8Rdy), 32'd0);
        nextCycle();
        avoidValid = 1'b0;
        @(negedge clk);
        checkOutput("t4.drop.wr", 32'(wr8), 32'd0);
        checkOutput("t4.drop.grant", 32'(gnt8), 32'(2'b01));
        nextCycle();
        @(negedge clk);
        checkWrite(8, "t4.p1", 1'b1, 16'hE001, SRC_PWM, 2'b10);
        checkOutput("t4.p1.prdy", 32'(p8Rdy), 32'd1);

        // Async reset in the middle of a PWM burst, then a tie goes to Avoidance
        rst = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b1, 16'hF001, 1'b0, 1'b0);
        releaseReset();
        nextCycle();
        @(negedge clk);
        checkWrite(4, "t5.p1", 1'b1, 16'hF001, SRC_PWM, 2'b10);
        nextCycle();
        pwmData = 16'hF002;
        @(negedge clk);
        checkWrite(4, "t5.p2", 1'b1, 16'hF002, SRC_PWM, 2'b10);
        nextCycle();
        pwmData = 16'hF003;
        #2;
        rst = 1'b1;
        #1;
        checkReset("t5.async");
        avoidValid = 1'b1;
        avoidData  = 16'hA001;
        releaseReset();
        @(negedge clk);
        checkOutput("t5.idle.grant", 32'(gnt4), 32'(2'b00));
        nextCycle();
        @(negedge clk);
        checkWrite(4, "t5.tie.u4", 1'b1, 16'hA001, SRC_AVOID, 2'b01);
        checkWrite(8, "t5.tie.u8", 1'b1, 16'hA001, SRC_AVOID, 2'b01);

        // Avoidance counter wraps after 65536 transfers
        rst = 1'b1;
        applyStimulus(1'b1, 16'h5555, 1'b0, 16'h0, 1'b0, 1'b0);
        releaseReset();
        repeat (65536) nextCycle();
        checkOutput("t6.full", 32'(acnt8), 32'h0000FFFF);
        nextCycle();
        checkOutput("t6.wrap.u8", 32'(acnt8), 32'd0);
        checkOutput("t6.wrap.u4", 32'(acnt4), 32'd0);
        checkOutput("t6.pwm", 32'(pcnt8), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
